// File: rtl/zebra_ctrl_pkg.sv
// Shared types for the zebra-crossing detection controller.
//   state_e : 3-bit controller state encoding, also driven on the state output
//   RUNS_W  : width of the detector long-run count
//   FCNT_W  : width of the per-session frame counter
package zebra_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEARCH  = 3'd1,
    ST_CONFIRM = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_RELEASE = 3'd4
  } state_e;

  localparam int RUNS_W = 8;
  localparam int FCNT_W = 16;

endpackage

// File: rtl/zebra_detect_controller_if.sv
// Control / detector / event bundle of the zebra detection controller.
//   master : session control, detector results and evt_ready (driver side)
//   slave  : controller side, produces stream gate, event, status outputs
interface zebra_detect_controller_if;
  import zebra_ctrl_pkg::*;

  logic              start;
  logic              stop;
  logic              det_valid;
  logic              det_zebra;
  logic [RUNS_W-1:0] det_runs;
  logic              evt_ready;

  logic              stream_en;
  logic              evt_valid;
  logic              evt_zebra;
  logic [RUNS_W-1:0] evt_runs;
  logic              evt_drop;
  logic              timeout_err;
  logic [2:0]        state;
  logic [FCNT_W-1:0] frame_cnt;

  modport master (
    output start, stop, det_valid, det_zebra, det_runs, evt_ready,
    input  stream_en, evt_valid, evt_zebra, evt_runs, evt_drop,
           timeout_err, state, frame_cnt
  );

  modport slave (
    input  start, stop, det_valid, det_zebra, det_runs, evt_ready,
    output stream_en, evt_valid, evt_zebra, evt_runs, evt_drop,
           timeout_err, state, frame_cnt
  );

endinterface

// File: rtl/zebra_detect_controller.sv
// Zebra-crossing detection session controller.
// Debounces per-frame detector results into acquire/lost events using
// consecutive-frame hysteresis, with a single-entry event register,
// a frame-gap watchdog and a per-session frame counter.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : zebra_detect_controller_if.slave (start/stop, detector strobe,
//          evt handshake, stream_en, timeout_err, state, frame_cnt)
module zebra_detect_controller
  import zebra_ctrl_pkg::*;
#(
  parameter int CONFIRM_FRAMES = 3,
  parameter int RELEASE_FRAMES = 2,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input logic                      clk,
  input logic                      rst,
  zebra_detect_controller_if.slave bus
);

  localparam int              WD_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      HIT_LAST  = 8'(CONFIRM_FRAMES);
  localparam logic [7:0]      MISS_LAST = 8'(RELEASE_FRAMES);

  state_e            r_state, w_nxt_state;
  logic [7:0]        r_hit, w_nxt_hit;
  logic [7:0]        r_miss, w_nxt_miss;
  logic [WD_W-1:0]   r_wd, w_nxt_wd;
  logic              r_err;
  logic [FCNT_W-1:0] r_fcnt;
  logic              r_evt_valid, r_evt_zebra, r_evt_drop;
  logic [RUNS_W-1:0] r_evt_runs;

  logic w_active, w_start_ok, w_frame, w_pos, w_neg, w_timeout;
  logic w_evt_new, w_evt_zebra;

  // stop dominates everything, so a frame coincident with stop is not seen
  assign w_active   = (r_state != ST_IDLE);
  assign w_start_ok = !w_active && bus.start && !bus.stop;
  assign w_frame    = w_active && bus.det_valid && !bus.stop;
  assign w_pos      = w_frame && bus.det_zebra;
  assign w_neg      = w_frame && !bus.det_zebra;
  assign w_timeout  = w_active && !bus.stop && !bus.det_valid && (r_wd == WD_LAST);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_hit   = r_hit;
    w_nxt_miss  = r_miss;
    w_nxt_wd    = r_wd;
    w_evt_new   = 1'b0;
    w_evt_zebra = 1'b0;
    if (bus.stop || w_timeout) begin
      w_nxt_state = ST_IDLE;
      w_nxt_hit   = '0;
      w_nxt_miss  = '0;
      w_nxt_wd    = '0;
    end else begin
      if (w_active) w_nxt_wd = bus.det_valid ? '0 : r_wd + 1'b1;
      unique case (r_state)
        ST_IDLE: if (bus.start) begin
          w_nxt_state = ST_SEARCH;
          w_nxt_hit   = '0;
          w_nxt_miss  = '0;
          w_nxt_wd    = '0;
        end
        ST_SEARCH: if (w_pos) begin
          if (CONFIRM_FRAMES == 1) begin
            w_nxt_state = ST_LOCKED;
            w_nxt_hit   = '0;
            w_evt_new   = 1'b1;
            w_evt_zebra = 1'b1;
          end else begin
            w_nxt_state = ST_CONFIRM;
            w_nxt_hit   = 8'd1;
          end
        end
        ST_CONFIRM: if (w_pos) begin
          if (r_hit + 8'd1 == HIT_LAST) begin
            w_nxt_state = ST_LOCKED;
            w_nxt_hit   = '0;
            w_evt_new   = 1'b1;
            w_evt_zebra = 1'b1;
          end else begin
            w_nxt_hit = r_hit + 8'd1;
          end
        end else if (w_neg) begin
          w_nxt_state = ST_SEARCH;
          w_nxt_hit   = '0;
        end
        ST_LOCKED: if (w_neg) begin
          if (RELEASE_FRAMES == 1) begin
            w_nxt_state = ST_SEARCH;
            w_nxt_miss  = '0;
            w_evt_new   = 1'b1;
          end else begin
            w_nxt_state = ST_RELEASE;
            w_nxt_miss  = 8'd1;
          end
        end
        ST_RELEASE: if (w_pos) begin
          w_nxt_state = ST_LOCKED;
          w_nxt_miss  = '0;
        end else if (w_neg) begin
          if (r_miss + 8'd1 == MISS_LAST) begin
            w_nxt_state = ST_SEARCH;
            w_nxt_miss  = '0;
            w_evt_new   = 1'b1;
          end else begin
            w_nxt_miss = r_miss + 8'd1;
          end
        end
        default: w_nxt_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_hit   <= '0;
      r_miss  <= '0;
      r_wd    <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_hit   <= w_nxt_hit;
      r_miss  <= w_nxt_miss;
      r_wd    <= w_nxt_wd;
    end
  end

  // Event register: a new event always loads; it counts as a drop only if the
  // old one was still pending and not being accepted on this same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_evt_valid <= 1'b0;
      r_evt_zebra <= 1'b0;
      r_evt_runs  <= '0;
      r_evt_drop  <= 1'b0;
      r_err       <= 1'b0;
      r_fcnt      <= '0;
    end else begin
      r_evt_drop <= 1'b0;
      if (w_evt_new) begin
        r_evt_valid <= 1'b1;
        r_evt_zebra <= w_evt_zebra;
        r_evt_runs  <= bus.det_runs;
        r_evt_drop  <= r_evt_valid && !bus.evt_ready;
      end else if (r_evt_valid && bus.evt_ready) begin
        r_evt_valid <= 1'b0;
      end
      if (w_timeout)       r_err <= 1'b1;
      else if (w_start_ok) r_err <= 1'b0;
      if (w_start_ok)                   r_fcnt <= '0;
      else if (w_frame && r_fcnt != '1) r_fcnt <= r_fcnt + 1'b1;
    end
  end

  assign bus.stream_en   = w_active;
  assign bus.state       = r_state;
  assign bus.evt_valid   = r_evt_valid;
  assign bus.evt_zebra   = r_evt_zebra;
  assign bus.evt_runs    = r_evt_runs;
  assign bus.evt_drop    = r_evt_drop;
  assign bus.timeout_err = r_err;
  assign bus.frame_cnt   = r_fcnt;

endmodule

// File: tb/tb_zebra_detect_controller.sv
// Randomized self-checking bench for zebra_detect_controller with a
// frame-streak reference model plus directed scenarios.
module tb_zebra_detect_controller;
  localparam int CF = 3;
  localparam int RF = 2;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  zebra_detect_controller_if bus();

  zebra_detect_controller #(
    .CONFIRM_FRAMES(CF), .RELEASE_FRAMES(RF), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model: session flag, lock flag, streak lengths, gap counter
  bit         m_active, m_locked, m_err, m_ev, m_ez, m_drop;
  int         m_pos, m_neg, m_wd, m_fc;
  logic [7:0] m_er;
  bit         rdy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] m_code();
    if (!m_active) return 3'd0;
    if (!m_locked) return (m_pos == 0) ? 3'd1 : 3'd2;
    return (m_neg == 0) ? 3'd3 : 3'd4;
  endfunction

  task automatic model_reset();
    m_active = 0; m_locked = 0; m_err = 0; m_ev = 0; m_ez = 0; m_drop = 0;
    m_pos = 0; m_neg = 0; m_wd = 0; m_fc = 0; m_er = '0;
  endtask

  task automatic model_step(input bit st, input bit sp, input bit dv, input bit dz,
                            input logic [7:0] rn, input bit rd);
    bit ev_new, ev_z;
    ev_new = 0; ev_z = 0;
    if (sp) begin
      m_active = 0; m_locked = 0; m_pos = 0; m_neg = 0; m_wd = 0;
    end else if (!m_active) begin
      if (st) begin
        m_active = 1; m_err = 0; m_fc = 0; m_wd = 0;
        m_locked = 0; m_pos = 0; m_neg = 0;
      end
    end else if (dv) begin
      m_wd = 0;
      if (m_fc < 65535) m_fc++;
      if (!m_locked) begin
        if (dz) begin
          m_pos++;
          if (m_pos == CF) begin m_locked = 1; m_pos = 0; ev_new = 1; ev_z = 1; end
        end else m_pos = 0;
      end else begin
        if (!dz) begin
          m_neg++;
          if (m_neg == RF) begin m_locked = 0; m_neg = 0; ev_new = 1; ev_z = 0; end
        end else m_neg = 0;
      end
    end else if (m_wd == TO - 1) begin
      m_active = 0; m_err = 1; m_locked = 0; m_pos = 0; m_neg = 0; m_wd = 0;
    end else begin
      m_wd++;
    end
    m_drop = 0;
    if (ev_new) begin
      m_drop = m_ev && !rd;
      m_ev = 1; m_ez = ev_z; m_er = rn;
    end else if (m_ev && rd) begin
      m_ev = 0;
    end
  endtask

  task automatic check_all();
    chk("state",     32'(bus.state),       32'(m_code()));
    chk("stream_en", 32'(bus.stream_en),   32'(m_active));
    chk("evt_valid", 32'(bus.evt_valid),   32'(m_ev));
    chk("evt_zebra", 32'(bus.evt_zebra),   32'(m_ez));
    chk("evt_runs",  32'(bus.evt_runs),    32'(m_er));
    chk("evt_drop",  32'(bus.evt_drop),    32'(m_drop));
    chk("tmo_err",   32'(bus.timeout_err), 32'(m_err));
    chk("frame_cnt", 32'(bus.frame_cnt),   32'(m_fc));
  endtask

  // one clock: check previous edge's result, apply inputs, advance model
  task automatic drive(input bit st, input bit sp, input bit dv, input bit dz,
                       input logic [7:0] rn);
    @(negedge clk);
    check_all();
    bus.start = st; bus.stop = sp; bus.det_valid = dv;
    bus.det_zebra = dz; bus.det_runs = rn; bus.evt_ready = rdy;
    model_step(st, sp, dv, dz, rn, rdy);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 8'h00);
  endtask

  task automatic frame(input bit dz, input logic [7:0] rn);
    drive(0, 0, 1, dz, rn);
  endtask

  initial begin
    bus.start = 0; bus.stop = 0; bus.det_valid = 0; bus.det_zebra = 0;
    bus.det_runs = '0; bus.evt_ready = 0;
    rdy = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_stream", 32'(bus.stream_en), 32'd0);
    check_all();
    rst = 0;

    // acquire after three positive frames, event pending with ready low
    drive(1, 0, 0, 0, 8'h00);
    frame(1, 8'h11); idle(2); frame(1, 8'h22); frame(1, 8'h5A);
    #1;
    chk("acq_state", 32'(bus.state), 32'd3);
    chk("acq_valid", 32'(bus.evt_valid), 32'd1);
    chk("acq_zebra", 32'(bus.evt_zebra), 32'd1);
    chk("acq_runs", 32'(bus.evt_runs), 32'h5A);

    // 0,1,0,0 from LOCKED: back to LOCKED after the 1, lost only at end
    frame(0, 8'h01); #1 chk("rel_state", 32'(bus.state), 32'd4);
    frame(1, 8'h02); #1 chk("relock_state", 32'(bus.state), 32'd3);
    frame(0, 8'h03);
    frame(0, 8'h04);
    #1;
    chk("lost_state", 32'(bus.state), 32'd1);
    chk("lost_drop", 32'(bus.evt_drop), 32'd1);
    chk("lost_zebra", 32'(bus.evt_zebra), 32'd0);
    chk("lost_runs", 32'(bus.evt_runs), 32'h04);
    idle(3);
    rdy = 1; idle(1); rdy = 0;
    #1 chk("accept_valid", 32'(bus.evt_valid), 32'd0);

    // watchdog: no frames for TO cycles after start
    drive(0, 1, 0, 0, 8'h00);
    drive(1, 0, 0, 0, 8'h00);
    idle(TO - 1);
    #1 chk("wd_before", 32'(bus.state), 32'd1);
    idle(1);
    #1;
    chk("wd_state", 32'(bus.state), 32'd0);
    chk("wd_err", 32'(bus.timeout_err), 32'd1);
    drive(1, 0, 0, 0, 8'h00);
    #1 chk("wd_err_clr", 32'(bus.timeout_err), 32'd0);

    // stop coincident with the third positive frame
    rdy = 1;
    frame(1, 8'h31); frame(1, 8'h32);
    drive(0, 1, 1, 1, 8'h33);
    #1;
    chk("stop_state", 32'(bus.state), 32'd0);
    chk("stop_stream", 32'(bus.stream_en), 32'd0);
    chk("stop_evt", 32'(bus.evt_valid), 32'd0);

    // randomized segments with varying frame rate, bias and back-pressure
    for (int seg = 0; seg < 24; seg++) begin
      int dv_pct, z_pct, rdy_pct;
      dv_pct  = (seg % 6 == 5) ? 0 : $urandom_range(15, 70);
      z_pct   = $urandom_range(20, 90);
      rdy_pct = $urandom_range(0, 100);
      for (int c = 0; c < 160; c++) begin
        bit st, sp, dv, dz;
        st  = ($urandom_range(0, 7) == 0);
        sp  = ($urandom_range(0, 199) == 0);
        dv  = ($urandom_range(0, 99) < dv_pct);
        dz  = ($urandom_range(0, 99) < z_pct);
        rdy = ($urandom_range(0, 99) < rdy_pct);
        drive(st, sp, dv, dz, 8'($urandom_range(0, 255)));
      end
    end

    // async reset while in CONFIRM with an event pending
    rdy = 0;
    drive(0, 1, 0, 0, 8'h00);
    drive(1, 0, 0, 0, 8'h00);
    frame(1, 8'h41); frame(1, 8'h42); frame(1, 8'h43);
    frame(0, 8'h44); frame(0, 8'h45);
    frame(1, 8'h46);
    @(negedge clk);
    check_all();
    chk("pre_rst_state", 32'(bus.state), 32'd2);
    chk("pre_rst_evt", 32'(bus.evt_valid), 32'd1);
    #1 rst = 1;
    #1;
    chk("arst_state", 32'(bus.state), 32'd0);
    chk("arst_stream", 32'(bus.stream_en), 32'd0);
    chk("arst_valid", 32'(bus.evt_valid), 32'd0);
    chk("arst_zebra", 32'(bus.evt_zebra), 32'd0);
    chk("arst_runs", 32'(bus.evt_runs), 32'd0);
    chk("arst_drop", 32'(bus.evt_drop), 32'd0);
    chk("arst_err", 32'(bus.timeout_err), 32'd0);
    chk("arst_fcnt", 32'(bus.frame_cnt), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    drive(1, 0, 0, 0, 8'h00);
    frame(1, 8'h51);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/zebra_detect_controller.md
ZEBRA_DETECT_CONTROLLER -- requirements
Module: zebra_detect_controller

Interface
REQ-001 Parameter CONFIRM_FRAMES, default 3: consecutive positive frames needed to enter LOCKED (range 1-255).
REQ-002 Parameter RELEASE_FRAMES, default 2: consecutive negative frames needed to leave LOCKED (range 1-255).
REQ-003 Parameter TIMEOUT_CYCLES, default 200000: max clk cycles between det_valid pulses while active.
REQ-004 clk  in  1  sole clock, all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  single-cycle pulse, begin detection session.
REQ-007 stop  in  1  single-cycle pulse, end session.
REQ-008 det_valid  in  1  per-frame result strobe from the zebra detector.
REQ-009 det_zebra  in  1  frame-level zebra flag, qualified by det_valid.
REQ-010 det_runs  in  8  long-run count, qualified by det_valid.
REQ-011 stream_en  out  1  gates pixel stream into the detector; 1 in every state except IDLE.
REQ-012 evt_valid / evt_ready  out/in  1  event handshake; transfer when both high.
REQ-013 evt_zebra  out  1  1 = crossing acquired, 0 = crossing lost.
REQ-014 evt_runs  out  8  det_runs of the frame that caused the event.
REQ-015 evt_drop  out  1  one-cycle pulse when a pending event is overwritten.
REQ-016 timeout_err  out  1  sticky watchdog flag.
REQ-017 state  out  3  current FSM state encoding.
REQ-018 frame_cnt  out  16  frames seen this session.

Function
REQ-019 States IDLE, SEARCH, CONFIRM, LOCKED, RELEASE; all transitions registered, effective the cycle after the qualifying input.
REQ-020 IDLE: start -> SEARCH; det_valid ignored.
REQ-021 SEARCH: det_valid&det_zebra -> hit_cnt=1, CONFIRM, or LOCKED with acquire event if CONFIRM_FRAMES==1; negative frame stays SEARCH.
REQ-022 CONFIRM: positive frame -> hit_cnt+1, LOCKED with acquire event when hit_cnt reaches CONFIRM_FRAMES; negative frame -> SEARCH, hit_cnt=0.
REQ-023 LOCKED: negative frame -> miss_cnt=1, RELEASE, or SEARCH with lost event if RELEASE_FRAMES==1; positive frame stays LOCKED.
REQ-024 RELEASE: positive frame -> LOCKED, miss_cnt=0; negative frame -> miss_cnt+1, SEARCH with lost event when miss_cnt reaches RELEASE_FRAMES.
REQ-025 stop in any state -> IDLE, hit_cnt/miss_cnt/watchdog cleared; stop wins over simultaneous start or det_valid.
REQ-026 start outside IDLE ignored.
REQ-027 Event register single-entry: evt_valid, evt_zebra, evt_runs load on the same edge as the causing transition; held stable until accepted.
REQ-028 New event while evt_valid&!evt_ready: overwrite, evt_drop pulses one cycle; new event coincident with acceptance: load, no drop, evt_valid stays 1.
REQ-029 Pending event survives stop.
REQ-030 Watchdog counts cycles outside IDLE, clears on det_valid and entry from IDLE; reaching TIMEOUT_CYCLES-1 -> IDLE, timeout_err=1.
REQ-031 timeout_err clears only on accepted start or rst.
REQ-032 frame_cnt increments on det_valid outside IDLE, saturates at 16'hFFFF, clears on accepted start.

Reset
REQ-033 rst: state=IDLE, stream_en=0, evt_valid=0, evt_zebra=0, evt_runs=0, evt_drop=0, timeout_err=0, frame_cnt=0, internal counters 0.
REQ-034 rst mid-session discards any pending event.

Structure
REQ-035 State enum and its 3-bit encoding live in shared package zebra_ctrl_pkg.
REQ-036 Single module; no sub-module; event register implemented inline.

Verification
REQ-037 start, frames 1,1,1 -> acquire event (evt_zebra=1, evt_runs=last det_runs) one cycle after third det_valid, state LOCKED.
REQ-038 From LOCKED, frames 0,1,0,0 -> returns to LOCKED after the 1, lost event only after final 0, state SEARCH.
REQ-039 evt_ready=0, acquire then lost occur -> evt_drop pulses once, evt_zebra=0 held until evt_ready=1.
REQ-040 TIMEOUT_CYCLES=100, no det_valid after start -> IDLE and timeout_err=1 at cycle 100; next start clears it.
REQ-041 stop coincident with third positive det_valid -> IDLE, no event, stream_en=0.
REQ-042 rst asserted during CONFIRM with pending event -> all outputs at reset values asynchronously.
